// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the register file: clears every register after reset,
// then shares the port between two writeback requesters with round-robin arbitration.
module regfile_write_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int ZERO_X0    = 1,
  parameter int PRIO_RESET = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_writereg,
  output logic [DATA_W-1:0] rf_writedata,
  output logic              grant_id,
  output logic              init_done,
  output logic              err_oob
);

  localparam int CNT_W = $clog2(NUM_REGS) + 1;

  typedef enum logic {S_CLEAR, S_ARB} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_last_grant;
  logic                r_rf_regwrite;
  logic [ADDR_W-1:0]   r_rf_writereg;
  logic [DATA_W-1:0]   r_rf_writedata;
  logic                r_grant_id;
  logic                r_init_done;
  logic                r_err_oob;

  logic                w_arb;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_oob;
  logic                w_zero_drop;

  // On a tie the requester that did not win last time gets the port.
  assign w_arb       = (r_state == S_ARB) && !reset;
  assign w_grant0    = w_arb && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1    = w_arb && req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept    = w_grant0 || w_grant1;
  assign w_addr      = w_grant1 ? req1_addr : req0_addr;
  assign w_data      = w_grant1 ? req1_data : req0_data;
  assign w_oob       = 32'(w_addr) >= 32'(NUM_REGS);
  assign w_zero_drop = (ZERO_X0 != 0) && (w_addr == '0);

  assign req0_ready   = w_grant0;
  assign req1_ready   = w_grant1;
  assign rf_regwrite  = r_rf_regwrite;
  assign rf_writereg  = r_rf_writereg;
  assign rf_writedata = r_rf_writedata;
  assign grant_id     = r_grant_id;
  assign init_done    = r_init_done;
  assign err_oob      = r_err_oob;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_CLEAR;
      r_cnt          <= '0;
      r_last_grant   <= (PRIO_RESET != 0);
      r_rf_regwrite  <= 1'b0;
      r_rf_writereg  <= '0;
      r_rf_writedata <= '0;
      r_grant_id     <= 1'b0;
      r_init_done    <= 1'b0;
      r_err_oob      <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_rf_regwrite  <= 1'b1;
          r_rf_writereg  <= ADDR_W'(r_cnt);
          r_rf_writedata <= '0;
          r_grant_id     <= 1'b0;
          r_err_oob      <= 1'b0;
          if (r_cnt == CNT_W'(NUM_REGS - 1)) begin
            r_state     <= S_ARB;
            r_init_done <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ARB: begin
          if (w_accept) begin
            r_last_grant   <= w_grant1;
            r_rf_writereg  <= w_addr;
            r_rf_writedata <= w_data;
            r_grant_id     <= w_grant1;
            r_rf_regwrite  <= !w_oob && !w_zero_drop;
            r_err_oob      <= w_oob;
          end else begin
            r_rf_regwrite <= 1'b0;
            r_err_oob     <= 1'b0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
